// File: rtl/run_capture_monitor.sv
// On-chip run recorder: counts ap_done executions, accumulates per-channel word counts
// and rotate-XOR checksums, then streams the results out as 4-bit nibbles.
module run_capture_monitor #(
    parameter int NUM_CH   = 1,
    parameter int DATA_W   = 32,
    parameter int MAX_RUNS = 2,
    parameter int CNT_W    = 6
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst,
    input  logic                     ap_done,
    input  logic [NUM_CH-1:0]        ch_write,
    input  logic [NUM_CH*DATA_W-1:0] ch_din,
    input  logic                     data_ready,
    output logic [3:0]               data_out,
    output logic                     data_valid,
    output logic [CNT_W-1:0]         exe_cnt,
    output logic                     finished,
    output logic                     probe_out
);

    localparam int CS_NIB = DATA_W / 4;
    localparam int PER    = CS_NIB + 8;
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int POS_W  = $clog2(PER);

    typedef enum logic [1:0] {
        RUN,
        DUMP,
        DONE
    } state_t;

    state_t                        state;
    logic [NUM_CH-1:0][31:0]       cnt_q;
    logic [NUM_CH-1:0][31:0]       cnt_nx;
    logic [NUM_CH-1:0][DATA_W-1:0] csum_q;
    logic [NUM_CH-1:0][DATA_W-1:0] csum_nx;
    logic [CH_W-1:0]               ch_sel;
    logic [CH_W-1:0]               next_ch;
    logic [POS_W-1:0]              pos;
    logic [POS_W-1:0]              next_pos;
    logic [3:0]                    next_nib;
    logic                          last_nib;
    logic                          final_done;

    // Accumulators only move in RUN, so in DUMP the "next" values equal the frozen registers.
    always_comb begin
        cnt_nx  = cnt_q;
        csum_nx = csum_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (state == RUN && ch_write[i]) begin
                cnt_nx[i]  = cnt_q[i] + 32'd1;
                csum_nx[i] = {csum_q[i][DATA_W-2:0], csum_q[i][DATA_W-1]}
                             ^ ch_din[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            cnt_q  <= '0;
            csum_q <= '0;
        end else begin
            cnt_q  <= cnt_nx;
            csum_q <= csum_nx;
        end
    end

    assign last_nib   = (ch_sel == CH_W'(NUM_CH - 1)) && (pos == POS_W'(PER - 1));
    assign final_done = (state == RUN) && ap_done
                        && ((exe_cnt + CNT_W'(1)) == CNT_W'(MAX_RUNS));

    always_comb begin
        next_ch  = '0;
        next_pos = '0;
        if (state == DUMP) begin
            if (pos == POS_W'(PER - 1)) begin
                next_ch  = ch_sel + CH_W'(1);
                next_pos = '0;
            end else begin
                next_ch  = ch_sel;
                next_pos = pos + POS_W'(1);
            end
        end
    end

    // Reading through the *_nx values lets the first nibble include a write that
    // lands on the same edge as the final ap_done.
    always_comb begin
        next_nib = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int p = 0; p < CS_NIB; p++) begin
                if (next_ch == CH_W'(c) && next_pos == POS_W'(p)) begin
                    next_nib = csum_nx[c][DATA_W-1-4*p -: 4];
                end
            end
            for (int p = 0; p < 8; p++) begin
                if (next_ch == CH_W'(c) && next_pos == POS_W'(CS_NIB + p)) begin
                    next_nib = cnt_nx[c][31-4*p -: 4];
                end
            end
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state      <= RUN;
            data_out   <= '0;
            data_valid <= 1'b0;
            exe_cnt    <= '0;
            finished   <= 1'b0;
            probe_out  <= 1'b0;
            ch_sel     <= '0;
            pos        <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (ap_done) begin
                        exe_cnt   <= exe_cnt + CNT_W'(1);
                        probe_out <= ~probe_out;
                    end
                    if (final_done) begin
                        state      <= DUMP;
                        data_valid <= 1'b1;
                        data_out   <= next_nib;
                        ch_sel     <= '0;
                        pos        <= '0;
                    end
                end
                DUMP: begin
                    if (data_ready) begin
                        if (last_nib) begin
                            state      <= DONE;
                            data_valid <= 1'b0;
                            data_out   <= '0;
                            finished   <= 1'b1;
                        end else begin
                            ch_sel   <= next_ch;
                            pos      <= next_pos;
                            data_out <= next_nib;
                        end
                    end
                end
                DONE: begin
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_run_capture_monitor.sv
// Scoreboard bench for run_capture_monitor: a 2-channel 8-bit instance for the dump scenarios
// and a 1-channel 32-bit instance for the word-count wrap.
module tb_run_capture_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, done_a, ready_a, valid_a, fin_a, probe_a;
    logic [1:0]  wr_a;
    logic [15:0] din_a;
    logic [3:0]  out_a;
    logic [5:0]  exe_a;

    logic        rst_b, done_b, ready_b, valid_b, fin_b, probe_b;
    logic [0:0]  wr_b;
    logic [31:0] din_b;
    logic [3:0]  out_b;
    logic [5:0]  exe_b;

    int compared   = 0;
    int mismatched = 0;
    int cons_a     = 0;
    int cons_b     = 0;

    logic [3:0] exp_a[$];
    logic [3:0] exp_b[$];

    logic [3:0] basic_frame [20] = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2,
                                     4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    logic [3:0] sim_frame   [20] = '{4'h2, 4'h5, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2,
                                     4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    logic [3:0] wrap_frame  [16] = '{4'hD, 4'hE, 4'hA, 4'hD, 4'hB, 4'hE, 4'hE, 4'hF,
                                     4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};

    run_capture_monitor #(.NUM_CH(2), .DATA_W(8), .MAX_RUNS(2), .CNT_W(6)) u_a (
        .ap_clk(clk), .ap_rst(rst_a), .ap_done(done_a), .ch_write(wr_a), .ch_din(din_a),
        .data_ready(ready_a), .data_out(out_a), .data_valid(valid_a), .exe_cnt(exe_a),
        .finished(fin_a), .probe_out(probe_a)
    );

    run_capture_monitor #(.NUM_CH(1), .DATA_W(32), .MAX_RUNS(1), .CNT_W(6)) u_b (
        .ap_clk(clk), .ap_rst(rst_b), .ap_done(done_b), .ch_write(wr_b), .ch_din(din_b),
        .data_ready(ready_b), .data_out(out_b), .data_valid(valid_b), .exe_cnt(exe_b),
        .finished(fin_b), .probe_out(probe_b)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic reportMissing(input string name, input int got, input int want);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: got %0d, expected %0d", name, got, want);
    endtask

    // Consumed nibbles are popped from the expected queue; stalls must hold data_out steady.
    logic [3:0] held_a;
    bit         hold_a = 1'b0;
    always @(negedge clk) begin
        if (rst_a) begin
            hold_a = 1'b0;
        end else begin
            if (hold_a) begin
                checkOutput("stall_data_a", 32'(out_a), 32'(held_a));
                checkOutput("stall_valid_a", 32'(valid_a), 32'd1);
            end
            if (valid_a && ready_a) begin
                if (exp_a.size() == 0) reportMissing("extra_nibble_a", cons_a + 1, cons_a);
                else checkOutput("nibble_a", 32'(out_a), 32'(exp_a.pop_front()));
                cons_a++;
                hold_a = 1'b0;
            end else if (valid_a) begin
                hold_a = 1'b1;
                held_a = out_a;
            end else begin
                hold_a = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_b && valid_b && ready_b) begin
            if (exp_b.size() == 0) reportMissing("extra_nibble_b", cons_b + 1, cons_b);
            else checkOutput("nibble_b", 32'(out_b), 32'(exp_b.pop_front()));
            cons_b++;
        end
    end

    task automatic applyStimulus(input logic [1:0] wr, input logic [15:0] din, input logic done);
        wr_a   = wr;
        din_a  = din;
        done_a = done;
        @(posedge clk);
        #1;
        wr_a   = '0;
        din_a  = '0;
        done_a = 1'b0;
    endtask

    task automatic reset_a();
        rst_a = 1'b1;
        #2;
        checkOutput("rst_data_out", 32'(out_a), 32'd0);
        checkOutput("rst_valid", 32'(valid_a), 32'd0);
        checkOutput("rst_exe_cnt", 32'(exe_a), 32'd0);
        checkOutput("rst_finished", 32'(fin_a), 32'd0);
        checkOutput("rst_probe", 32'(probe_a), 32'd0);
        @(posedge clk);
        #1;
        rst_a = 1'b0;
        exp_a.delete();
    endtask

    task automatic push_frame_a(input logic [3:0] n [20]);
        foreach (n[i]) exp_a.push_back(n[i]);
    endtask

    // ch0: 0x12 then 0x34, two dones; the frame is expected once the final done issues.
    task automatic run_basic_a();
        applyStimulus(2'b01, 16'h0012, 1'b0);
        applyStimulus(2'b01, 16'h0034, 1'b0);
        applyStimulus(2'b00, 16'h0000, 1'b1);
        checkOutput("exe_after_first_done", 32'(exe_a), 32'd1);
        checkOutput("probe_after_first_done", 32'(probe_a), 32'd1);
        checkOutput("valid_before_final_done", 32'(valid_a), 32'd0);
        push_frame_a(basic_frame);
        applyStimulus(2'b00, 16'h0000, 1'b1);
        checkOutput("valid_after_final_done", 32'(valid_a), 32'd1);
        checkOutput("exe_after_final_done", 32'(exe_a), 32'd2);
    endtask

    task automatic wait_fin_a(input int bound, input bit bp, input bit frozen);
        int k = 0;
        while (!fin_a && k < bound) begin
            ready_a = bp ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
            if (frozen) begin
                wr_a   = (k % 3 == 0) ? 2'b11 : 2'b00;
                din_a  = 16'($urandom);
                done_a = (k % 5 == 1);
            end
            @(posedge clk);
            #1;
            k++;
        end
        wr_a    = '0;
        din_a   = '0;
        done_a  = 1'b0;
        ready_a = 1'b1;
        if (!fin_a) reportMissing("finish_timeout_a", k, bound);
    endtask

    task automatic check_end_a(input string tag);
        checkOutput({tag, "_finished"}, 32'(fin_a), 32'd1);
        checkOutput({tag, "_valid_low"}, 32'(valid_a), 32'd0);
        checkOutput({tag, "_exe_cnt"}, 32'(exe_a), 32'd2);
        checkOutput({tag, "_probe"}, 32'(probe_a), 32'd0);
        checkOutput({tag, "_queue_left"}, 32'(exp_a.size()), 32'd0);
    endtask

    initial begin
        rst_a = 1'b0; done_a = 1'b0; wr_a = '0; din_a = '0; ready_a = 1'b1;
        rst_b = 1'b0; done_b = 1'b0; wr_b = '0; din_b = '0; ready_b = 1'b1;
        @(posedge clk);
        #1;

        reset_a();
        run_basic_a();
        wait_fin_a(100, 1'b0, 1'b0);
        check_end_a("basic");

        for (int i = 0; i < 6; i++) applyStimulus(2'b11, 16'hA5C3, i[0]);
        check_end_a("done_frozen");

        reset_a();
        run_basic_a();
        wait_fin_a(200, 1'b1, 1'b1);
        check_end_a("backpressure");

        reset_a();
        applyStimulus(2'b01, 16'h0012, 1'b0);
        applyStimulus(2'b00, 16'h0000, 1'b1);
        push_frame_a(sim_frame);
        applyStimulus(2'b01, 16'h0001, 1'b1);
        wait_fin_a(100, 1'b0, 1'b0);
        check_end_a("simultaneous");

        reset_a();
        run_basic_a();
        begin
            int k = 0;
            int start = cons_a;
            ready_a = 1'b1;
            while (cons_a < start + 5 && k < 50) begin
                @(posedge clk);
                #1;
                k++;
            end
            if (cons_a < start + 5) reportMissing("midreset_progress", cons_a - start, 5);
        end
        reset_a();
        run_basic_a();
        wait_fin_a(100, 1'b0, 1'b0);
        check_end_a("after_midreset");

        rst_b = 1'b1;
        #2;
        checkOutput("b_rst_valid", 32'(valid_b), 32'd0);
        checkOutput("b_rst_probe", 32'(probe_b), 32'd0);
        @(posedge clk);
        #1;
        rst_b = 1'b0;
        @(negedge clk);
        force u_b.cnt_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release u_b.cnt_q;
        @(posedge clk);
        #1;
        foreach (wrap_frame[i]) exp_b.push_back(wrap_frame[i]);
        wr_b = 1'b1; din_b = 32'hDEAD_BEEF; done_b = 1'b1;
        @(posedge clk);
        #1;
        wr_b = 1'b0; din_b = '0; done_b = 1'b0;
        checkOutput("b_valid_after_done", 32'(valid_b), 32'd1);
        begin
            int k = 0;
            while (!fin_b && k < 60) begin
                @(posedge clk);
                #1;
                k++;
            end
            if (!fin_b) reportMissing("finish_timeout_b", k, 60);
        end
        checkOutput("b_exe_cnt", 32'(exe_b), 32'd1);
        checkOutput("b_frame_len", 32'(cons_b), 32'd16);
        checkOutput("b_queue_left", 32'(exp_b.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/run_capture_monitor.md
# run_capture_monitor

Synthesizable on-chip successor to the simulation-only output recorder used around HLS kernel wrappers. It sits beside the kernel inside the board wrapper and counts `ap_done` executions. For each of `NUM_CH` output streams it accumulates a word count and a rotate-XOR checksum. After `MAX_RUNS` executions it serializes the results as 4-bit nibbles on a ready/valid port, so run results can be checked on hardware without a simulator.

## Interface
- `NUM_CH`, default 1: number of monitored output streams, 1..8.
- `DATA_W`, default 32: stream data width; multiple of 4, 4..64.
- `MAX_RUNS`, default 2: executions to accumulate before dumping; 1..63.
- `CNT_W`, default 6: width of the execution counter; must satisfy 2^CNT_W > MAX_RUNS.

Ports (name, direction, width, meaning):
- `ap_clk`  in  1  single clock; all logic is on its rising edge.
- `ap_rst`  in  1  reset, asynchronous and active-high.
- `ap_done`  in  1  kernel completion pulse, sampled each cycle.
- `ch_write`  in  NUM_CH  per-channel write strobe; bit i is channel i.
- `ch_din`  in  NUM_CH*DATA_W  per-channel data; channel i occupies bits [i*DATA_W +: DATA_W].
- `data_ready`  in  1  consumer ready for the dump stream.
- `data_out`  out  4  current dump nibble.
- `data_valid`  out  1  `data_out` is valid.
- `exe_cnt`  out  CNT_W  number of completed executions counted so far.
- `finished`  out  1  dump complete; stays high until reset.
- `probe_out`  out  1  heartbeat; toggles on every counted `ap_done`.

## Operation
- **States:** RUN, DUMP, DONE. Reset enters RUN.
- **Reset values:** all outputs 0, all word counters 0, all checksums 0, nibble index 0.
- **RUN, channel write:** when `ch_write[i]`=1, `cnt[i]` <= `cnt[i]+1`.
  - `cnt[i]` is 32 bits and wraps modulo 2^32.
  - Checksum update: `csum[i]` <= rotl1(`csum[i]`) ^ `ch_din[i]`, where rotl1 is a 1-bit left rotate over DATA_W.
  - Channels update independently; several may update in the same cycle.
- **RUN, execution count:** when `ap_done`=1, `exe_cnt` increments and `probe_out` toggles.
  - If the new value equals MAX_RUNS, the state goes to DUMP.
  - Counters and checksums are never cleared between runs.
- **Simultaneous write and done:** a write in the same cycle as the final `ap_done` is included in the dump.
- **DUMP, frame order:** channel 0 first, up to channel NUM_CH-1. For each channel:
  - DATA_W/4 nibbles of `csum`, MSB nibble first;
  - then 8 nibbles of `cnt`, MSB nibble first.
- **DUMP, frame length:** total nibbles N = NUM_CH*(DATA_W/4+8).
- **DUMP, handshake:** a nibble is consumed on a cycle where `data_valid`=1 and `data_ready`=1.
  - While `data_ready`=0, `data_out` and `data_valid` hold stable.
  - `ch_write` and `ap_done` are ignored; counters, checksums and `exe_cnt` are frozen.
- **DUMP -> DONE:** on consumption of nibble N-1. DONE holds `data_valid`=0 and `finished`=1 until reset.
- **DONE:** all inputs are ignored.
- **Reset mid-operation:** `ap_rst` in any state returns immediately (asynchronously) to RUN with reset values. A partially sent frame is abandoned.

## Timing
- Counter and checksum updates are visible the cycle after the strobe.
- `exe_cnt` and `probe_out` change on the edge that samples `ap_done`.
- On the edge that samples the final `ap_done`, the block registers state DUMP, `data_valid`=1 and the first nibble, so the first nibble is valid one cycle after the final done.
- With `data_ready` held high, one nibble is sent per cycle with no bubbles. The last nibble is consumed N cycles after the first is presented.
- `finished` rises on the edge that consumes the last nibble; `data_valid` falls on the same edge.
- Every output is a register output; there is no combinational path from any input to any output.

## Test plan
- **Basic dump** (NUM_CH=2, DATA_W=8, MAX_RUNS=2): ch0 writes 0x12 then 0x34; ch1 writes nothing; `ap_done` twice; `data_ready`=1.
  - Required nibble stream: 1,0,0,0,0,0,0,0,0,2, then 0,0,0,0,0,0,0,0,0,0 (20 nibbles).
  - Then `finished`=1 and `exe_cnt`=2.
- **Backpressure:** same stimulus, `data_ready` toggling 1,0,0,1,...
  - Required: the same 20 nibbles in the same order, no duplicates, no drops.
  - `data_out` stable during every stall.
- **Simultaneous events:** ch0 writes 0x01 in the same cycle as the second `ap_done`.
  - Required: the dumped ch0 count includes that write; the checksum includes 0x01.
- **Frozen inputs:** writes and `ap_done` pulses during DUMP and DONE.
  - Required: no change to the dumped values; `exe_cnt` stays 2; `probe_out` does not toggle.
- **Reset mid-operation:** assert `ap_rst` after the 5th nibble, then rerun the basic scenario.
  - Required: all outputs 0 during reset, then the full identical 20-nibble frame.
- **Counter wrap and width** (NUM_CH=1, DATA_W=32, MAX_RUNS=1): `cnt` preloaded by 2^32-1 writes of 0 (or forced), plus one more write.
  - Required: dumped count 00000000 and a 16-nibble frame.
